// File: rtl/vector_wb_pkg.sv
`default_nettype none
// --------------------------------------------------------------------
// vector_wb_pkg: shared types and widths for the vector write-port block
// Rev 1.0
// --------------------------------------------------------------------
package vector_wb_pkg;

  localparam int NUM_ELEMS  = 4;
  localparam int ELEM_W     = 32;
  localparam int VREG_IDX_W = 2;
  localparam int ELEM_IDX_W = $clog2(NUM_ELEMS);
  localparam int ADDR_W     = 32;
  localparam int TO_CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/vector_wb_controller_if.sv
`default_nettype none
// --------------------------------------------------------------------
// vector_wb_controller_if: ALU, loader, memory and bank-side signals
// Rev 1.0
// --------------------------------------------------------------------
interface vector_wb_controller_if;
  import vector_wb_pkg::*;

  logic                  alu_valid;
  logic [VREG_IDX_W-1:0] alu_vd;
  logic [ELEM_W-1:0]     alu_w1;
  logic [ELEM_W-1:0]     alu_w2;
  logic [ELEM_W-1:0]     alu_w3;
  logic [ELEM_W-1:0]     alu_w4;

  logic                  ld_req;
  logic                  ld_ready;
  logic [VREG_IDX_W-1:0] ld_vd;
  logic [ADDR_W-1:0]     ld_base;
  logic                  ld_done;
  logic                  ld_err;

  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_valid;
  logic [ELEM_W-1:0]     mem_rdata;

  logic                  write_enable;
  logic                  write_imm;
  logic [VREG_IDX_W-1:0] vd;
  logic [ELEM_IDX_W-1:0] vindex;
  logic [ELEM_W-1:0]     imm;
  logic [ELEM_W-1:0]     vw1;
  logic [ELEM_W-1:0]     vw2;
  logic [ELEM_W-1:0]     vw3;
  logic [ELEM_W-1:0]     vw4;

  modport master (
    output alu_valid, alu_vd, alu_w1, alu_w2, alu_w3, alu_w4,
    output ld_req, ld_vd, ld_base, mem_valid, mem_rdata,
    input  ld_ready, ld_done, ld_err, mem_rd, mem_addr,
    input  write_enable, write_imm, vd, vindex, imm, vw1, vw2, vw3, vw4
  );

  modport slave (
    input  alu_valid, alu_vd, alu_w1, alu_w2, alu_w3, alu_w4,
    input  ld_req, ld_vd, ld_base, mem_valid, mem_rdata,
    output ld_ready, ld_done, ld_err, mem_rd, mem_addr,
    output write_enable, write_imm, vd, vindex, imm, vw1, vw2, vw3, vw4
  );

endinterface
`default_nettype wire

// File: rtl/vector_load_seq.sv
`default_nettype none
// --------------------------------------------------------------------
// vector_load_seq: fetches four words and offers them one element at a time
// Rev 1.0
// --------------------------------------------------------------------
module vector_load_seq
  import vector_wb_pkg::*;
#(
  parameter int STRIDE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_req,
  output logic                  ld_ready,
  input  logic [VREG_IDX_W-1:0] ld_vd,
  input  logic [ADDR_W-1:0]     ld_base,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_valid,
  input  logic [ELEM_W-1:0]     mem_rdata,
  output logic                  ld_done,
  output logic                  ld_err,
  output logic                  wr_req,
  output logic [VREG_IDX_W-1:0] wr_vd,
  output logic [ELEM_IDX_W-1:0] wr_idx,
  output logic [ELEM_W-1:0]     wr_data,
  input  logic                  wr_grant
);

  localparam logic [TO_CNT_W-1:0]   c_to_last   = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [ELEM_IDX_W-1:0] c_last_elem = ELEM_IDX_W'(NUM_ELEMS - 1);

  ld_state_t             r_state;
  ld_state_t             w_next;
  logic [VREG_IDX_W-1:0] r_vd;
  logic [ADDR_W-1:0]     r_base;
  logic [ELEM_IDX_W-1:0] r_idx;
  logic [TO_CNT_W-1:0]   r_cnt;
  logic                  r_pending;
  logic [ELEM_W-1:0]     r_data;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_timeout;

  // Plain modulo-2^32 add: a base near the top of memory wraps to 0.
  assign w_addr    = r_base + ADDR_W'(STRIDE) * ADDR_W'(r_idx);
  assign w_timeout = (r_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ld_req) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (mem_valid) w_next = WRITE;
               else if (w_timeout) w_next = IDLE;
      WRITE:   if (wr_grant) w_next = (r_idx == c_last_elem) ? DONE : ISSUE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    ld_done  = 1'b0;
    ld_err   = 1'b0;
    wr_req   = 1'b0;
    case (r_state)
      IDLE:    ld_ready = 1'b1;
      ISSUE:   begin
        mem_rd   = 1'b1;
        mem_addr = w_addr;
      end
      WAIT:    ld_err = ~mem_valid & w_timeout;
      WRITE:   wr_req = r_pending;
      DONE:    ld_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vd      <= '0;
      r_base    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        IDLE: if (ld_req) begin
          r_vd   <= ld_vd;
          r_base <= ld_base;
          r_idx  <= '0;
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (mem_valid) begin
            r_data    <= mem_rdata;
            r_pending <= 1'b1;
          end else if (w_timeout) begin
            r_pending <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WRITE: if (wr_grant) begin
          r_pending <= 1'b0;
          if (r_idx != c_last_elem) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_vd   = r_vd;
  assign wr_idx  = r_idx;
  assign wr_data = r_data;

endmodule
`default_nettype wire

// File: rtl/vector_wb_controller.sv
`default_nettype none
// --------------------------------------------------------------------
// vector_wb_controller: arbitrates ALU and vector-load writes into the bank
// Rev 1.0
// --------------------------------------------------------------------
module vector_wb_controller
  import vector_wb_pkg::*;
#(
  parameter int STRIDE  = 4,
  parameter int TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst,
  vector_wb_controller_if.slave bus
);

  logic                  w_wr_req;
  logic [VREG_IDX_W-1:0] w_wr_vd;
  logic [ELEM_IDX_W-1:0] w_wr_idx;
  logic [ELEM_W-1:0]     w_wr_data;
  logic                  w_grant;
  logic                  w_imm_fire;

  logic                  r_write_enable;
  logic                  r_write_imm;
  logic [VREG_IDX_W-1:0] r_vd;
  logic [ELEM_IDX_W-1:0] r_vindex;
  logic [ELEM_W-1:0]     r_imm;
  logic [ELEM_W-1:0]     r_vw1;
  logic [ELEM_W-1:0]     r_vw2;
  logic [ELEM_W-1:0]     r_vw3;
  logic [ELEM_W-1:0]     r_vw4;

  // The ALU cannot be stalled, so the loader only gets the port on idle ALU cycles.
  assign w_grant    = ~bus.alu_valid;
  assign w_imm_fire = w_wr_req & w_grant;

  vector_load_seq #(
    .STRIDE  (STRIDE),
    .TIMEOUT (TIMEOUT)
  ) u_load_seq (
    .clk       (clk),
    .rst       (rst),
    .ld_req    (bus.ld_req),
    .ld_ready  (bus.ld_ready),
    .ld_vd     (bus.ld_vd),
    .ld_base   (bus.ld_base),
    .mem_rd    (bus.mem_rd),
    .mem_addr  (bus.mem_addr),
    .mem_valid (bus.mem_valid),
    .mem_rdata (bus.mem_rdata),
    .ld_done   (bus.ld_done),
    .ld_err    (bus.ld_err),
    .wr_req    (w_wr_req),
    .wr_vd     (w_wr_vd),
    .wr_idx    (w_wr_idx),
    .wr_data   (w_wr_data),
    .wr_grant  (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_enable <= 1'b0;
      r_write_imm    <= 1'b0;
      r_vd           <= '0;
      r_vindex       <= '0;
      r_imm          <= '0;
      r_vw1          <= '0;
      r_vw2          <= '0;
      r_vw3          <= '0;
      r_vw4          <= '0;
    end else begin
      r_write_enable <= bus.alu_valid;
      r_write_imm    <= w_imm_fire;
      if (bus.alu_valid)  r_vd <= bus.alu_vd;
      else if (w_imm_fire) r_vd <= w_wr_vd;
      else                 r_vd <= '0;
      r_vindex <= w_imm_fire ? w_wr_idx  : '0;
      r_imm    <= w_imm_fire ? w_wr_data : '0;
      r_vw1    <= bus.alu_valid ? bus.alu_w1 : '0;
      r_vw2    <= bus.alu_valid ? bus.alu_w2 : '0;
      r_vw3    <= bus.alu_valid ? bus.alu_w3 : '0;
      r_vw4    <= bus.alu_valid ? bus.alu_w4 : '0;
    end
  end

  assign bus.write_enable = r_write_enable;
  assign bus.write_imm    = r_write_imm;
  assign bus.vd           = r_vd;
  assign bus.vindex       = r_vindex;
  assign bus.imm          = r_imm;
  assign bus.vw1          = r_vw1;
  assign bus.vw2          = r_vw2;
  assign bus.vw3          = r_vw3;
  assign bus.vw4          = r_vw4;

endmodule
`default_nettype wire

// File: tb/tb_vector_wb_controller.sv
`default_nettype none
// --------------------------------------------------------------------
// tb_vector_wb_controller: scoreboard bench for the vector write-port controller
// Rev 1.0
// --------------------------------------------------------------------
module tb_vector_wb_controller;

  localparam int TIMEOUT = 255;

  typedef struct {
    logic [1:0]  vd;
    logic [31:0] w1, w2, w3, w4;
    int          cyc;
  } alu_exp_t;

  typedef struct {
    logic [1:0]  vd;
    logic [1:0]  idx;
    logic [31:0] data;
    int          cyc;
  } imm_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  alu_exp_t    alu_q[$];
  imm_exp_t    imm_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem_q[$];

  vector_wb_controller_if bus ();

  vector_wb_controller #(.STRIDE(4), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_ld(input logic [1:0] v, input logic [31:0] b, output int c);
    bus.ld_req  = 1'b1;
    bus.ld_vd   = v;
    bus.ld_base = b;
    c = cyc;
    tick(1);
    bus.ld_req = 1'b0;
  endtask

  // Scoreboard: every bank write and memory read must match the head of its queue.
  task automatic monitor();
    alu_exp_t    ea;
    imm_exp_t    ei;
    logic [31:0] eaddr;
    forever begin
      @(negedge clk);
      if (bus.write_enable === 1'b1 || bus.write_imm === 1'b1) begin
        n_checks++;
        if (bus.write_enable === 1'b1 && bus.write_imm === 1'b1)
          $display("FAIL excl: write_enable=1 and write_imm=1 in cycle %0d, required not both", cyc);
        else n_pass++;
      end
      if (bus.write_enable === 1'b1) begin
        n_checks++;
        if (alu_q.size() == 0) begin
          $display("FAIL alu_write: unexpected write_enable vd=%0d in cycle %0d, required none", bus.vd, cyc);
        end else begin
          ea = alu_q.pop_front();
          if (bus.vd !== ea.vd || bus.vw1 !== ea.w1 || bus.vw2 !== ea.w2 || bus.vw3 !== ea.w3 ||
              bus.vw4 !== ea.w4 || cyc != ea.cyc)
            $display("FAIL alu_write: got vd=%0d vw=%h,%h,%h,%h cyc=%0d, expected vd=%0d vw=%h,%h,%h,%h cyc=%0d",
                     bus.vd, bus.vw1, bus.vw2, bus.vw3, bus.vw4, cyc, ea.vd, ea.w1, ea.w2, ea.w3, ea.w4, ea.cyc);
          else n_pass++;
        end
      end
      if (bus.write_imm === 1'b1) begin
        n_checks++;
        if (imm_q.size() == 0) begin
          $display("FAIL imm_write: unexpected write_imm vindex=%0d in cycle %0d, required none", bus.vindex, cyc);
        end else begin
          ei = imm_q.pop_front();
          if (bus.vd !== ei.vd || bus.vindex !== ei.idx || bus.imm !== ei.data || cyc != ei.cyc)
            $display("FAIL imm_write: got vd=%0d vindex=%0d imm=%h cyc=%0d, expected vd=%0d vindex=%0d imm=%h cyc=%0d",
                     bus.vd, bus.vindex, bus.imm, cyc, ei.vd, ei.idx, ei.data, ei.cyc);
          else n_pass++;
        end
      end
      if (bus.mem_rd === 1'b1) begin
        n_checks++;
        if (addr_q.size() == 0) begin
          $display("FAIL mem_addr: unexpected mem_rd addr=%h in cycle %0d, required none", bus.mem_addr, cyc);
        end else begin
          eaddr = addr_q.pop_front();
          if (bus.mem_addr !== eaddr)
            $display("FAIL mem_addr: got %h, expected %h", bus.mem_addr, eaddr);
          else n_pass++;
        end
      end
      if (bus.ld_done === 1'b1) done_cnt++;
      if (bus.ld_err === 1'b1) err_cnt++;
    end
  endtask

  // One-cycle-latency memory; stays silent when no response data is queued.
  task automatic mem_model();
    logic [31:0] d;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1 && mem_q.size() > 0) begin
        d = mem_q.pop_front();
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = d;
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (alu_q.size() != 0 || imm_q.size() != 0 || addr_q.size() != 0 || mem_q.size() != 0)
      $display("FAIL %s_drain: pending alu=%0d imm=%0d addr=%0d mem=%0d, expected all 0",
               name, alu_q.size(), imm_q.size(), addr_q.size(), mem_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    n_checks++;
    if (bus.ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b, expected 1", bus.ld_ready);
    else n_pass++;
    n_checks++;
    if ({bus.write_enable, bus.write_imm, bus.mem_rd, bus.ld_done, bus.ld_err} !== 5'b0)
      $display("FAIL reset_strobes: got we=%b wi=%b rd=%b done=%b err=%b, expected all 0",
               bus.write_enable, bus.write_imm, bus.mem_rd, bus.ld_done, bus.ld_err);
    else n_pass++;
    n_checks++;
    if ({bus.vd, bus.vindex, bus.imm, bus.mem_addr} !== 68'b0)
      $display("FAIL reset_fields: got vd=%0d vindex=%0d imm=%h addr=%h, expected 0",
               bus.vd, bus.vindex, bus.imm, bus.mem_addr);
    else n_pass++;
    n_checks++;
    if ({bus.vw1, bus.vw2, bus.vw3, bus.vw4} !== 128'b0)
      $display("FAIL reset_vw: got %h %h %h %h, expected 0", bus.vw1, bus.vw2, bus.vw3, bus.vw4);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1'b1;
    bus.alu_vd = 2'd2;
    bus.alu_w1 = 32'd1; bus.alu_w2 = 32'd2; bus.alu_w3 = 32'd3; bus.alu_w4 = 32'd4;
    alu_q.push_back('{vd: 2'd2, w1: 32'd1, w2: 32'd2, w3: 32'd3, w4: 32'd4, cyc: cyc + 1});
    tick(1);
    bus.alu_valid = 1'b0;
    bus.alu_w1 = '0; bus.alu_w2 = '0; bus.alu_w3 = '0; bus.alu_w4 = '0;
    tick(4);
    check_drained("alu_only");
  endtask

  task automatic test_back_to_back();
    logic [1:0] vds [3];
    vds[0] = 2'd0; vds[1] = 2'd1; vds[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1;
      bus.alu_vd = vds[k];
      bus.alu_w1 = $urandom; bus.alu_w2 = $urandom; bus.alu_w3 = $urandom; bus.alu_w4 = $urandom;
      alu_q.push_back('{vd: vds[k], w1: bus.alu_w1, w2: bus.alu_w2, w3: bus.alu_w3, w4: bus.alu_w4, cyc: cyc + 1});
      tick(1);
    end
    bus.alu_valid = 1'b0;
    tick(4);
    check_drained("back_to_back");
  endtask

  task automatic test_load();
    int c;
    int dcyc;
    bit got;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(32'h100 + 32'(4 * i));
      mem_q.push_back(32'hA0 + 32'(i));
    end
    c = cyc;
    for (int i = 0; i < 4; i++)
      imm_q.push_back('{vd: 2'd1, idx: 2'(i), data: 32'hA0 + 32'(i), cyc: c + 4 + 3 * i});
    issue_ld(2'd1, 32'h100, c);
    @(negedge clk);
    n_checks++;
    if (bus.ld_ready !== 1'b0) $display("FAIL load_busy: ld_ready got %b, expected 0", bus.ld_ready);
    else n_pass++;
    got = 0;
    dcyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.ld_done === 1'b1) begin
        got = 1;
        dcyc = cyc;
      end
    end
    n_checks++;
    if (!got || dcyc != c + 13) $display("FAIL load_done: got seen=%0d cyc=%0d, expected cyc=%0d", got, dcyc, c + 13);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.ld_ready !== 1'b1) $display("FAIL load_ready_after: got %b, expected 1", bus.ld_ready);
    else n_pass++;
    tick(2);
    check_drained("load");
  endtask

  task automatic test_collision();
    int c;
    int dcyc;
    bit got;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(32'h500 + 32'(4 * i));
      mem_q.push_back(32'hD0 + 32'(i));
    end
    c = cyc;
    for (int i = 0; i < 4; i++)
      imm_q.push_back('{vd: 2'd1, idx: 2'(i), data: 32'hD0 + 32'(i), cyc: (i < 2) ? c + 4 + 3 * i : c + 7 + 3 * i});
    issue_ld(2'd1, 32'h500, c);
    while (cyc < c + 9) tick(1);
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1;
      bus.alu_vd = 2'd1;
      bus.alu_w1 = $urandom; bus.alu_w2 = $urandom; bus.alu_w3 = $urandom; bus.alu_w4 = $urandom;
      alu_q.push_back('{vd: 2'd1, w1: bus.alu_w1, w2: bus.alu_w2, w3: bus.alu_w3, w4: bus.alu_w4, cyc: cyc + 1});
      tick(1);
    end
    bus.alu_valid = 1'b0;
    got = 0;
    dcyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.ld_done === 1'b1) begin
        got = 1;
        dcyc = cyc;
      end
    end
    n_checks++;
    if (!got || dcyc != c + 16) $display("FAIL collision_done: got seen=%0d cyc=%0d, expected cyc=%0d", got, dcyc, c + 16);
    else n_pass++;
    tick(3);
    check_drained("collision");
  endtask

  task automatic test_timeout();
    int c;
    int ecyc;
    int err0;
    int done0;
    bit got;
    err0 = err_cnt;
    done0 = done_cnt;
    addr_q.push_back(32'h600);
    issue_ld(2'd2, 32'h600, c);
    got = 0;
    ecyc = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (bus.ld_err === 1'b1) begin
        got = 1;
        ecyc = cyc;
      end
    end
    n_checks++;
    if (!got || ecyc != c + 1 + TIMEOUT)
      $display("FAIL timeout_err: got seen=%0d cyc=%0d, expected cyc=%0d", got, ecyc, c + 1 + TIMEOUT);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.ld_ready !== 1'b1) $display("FAIL timeout_ready: got %b, expected 1", bus.ld_ready);
    else n_pass++;
    tick(5);
    n_checks++;
    if (err_cnt - err0 != 1 || done_cnt != done0)
      $display("FAIL timeout_pulses: got err=%0d done=%0d, expected err=1 done=0", err_cnt - err0, done_cnt - done0);
    else n_pass++;
    check_drained("timeout");
  endtask

  task automatic test_wrap_busy();
    int c;
    int done0;
    logic [31:0] addrs [4];
    addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC; addrs[2] = 32'h0; addrs[3] = 32'h4;
    done0 = done_cnt;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(addrs[i]);
      mem_q.push_back(32'hB0 + 32'(i));
      imm_q.push_back('{vd: 2'd3, idx: 2'(i), data: 32'hB0 + 32'(i), cyc: c + 4 + 3 * i});
    end
    issue_ld(2'd3, 32'hFFFF_FFF8, c);
    while (cyc < c + 5) tick(1);
    bus.ld_req = 1'b1;
    bus.ld_vd = 2'd0;
    bus.ld_base = 32'h700;
    tick(1);
    bus.ld_req = 1'b0;
    tick(30);
    n_checks++;
    if (done_cnt - done0 != 1) $display("FAIL wrap_done_count: got %0d, expected 1", done_cnt - done0);
    else n_pass++;
    check_drained("wrap_busy");
  endtask

  task automatic test_reset_mid_load();
    int c;
    int done0;
    int err0;
    done0 = done_cnt;
    err0 = err_cnt;
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(32'h800 + 32'(4 * i));
      mem_q.push_back(32'hC0 + 32'(i));
    end
    for (int i = 0; i < 2; i++)
      imm_q.push_back('{vd: 2'd2, idx: 2'(i), data: 32'hC0 + 32'(i), cyc: c + 4 + 3 * i});
    issue_ld(2'd2, 32'h800, c);
    while (cyc < c + 7) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ld_ready !== 1'b1) $display("FAIL midreset_ready: got %b, expected 1", bus.ld_ready);
    else n_pass++;
    n_checks++;
    if ({bus.write_enable, bus.write_imm, bus.mem_rd, bus.ld_done, bus.ld_err, bus.vd, bus.imm, bus.mem_addr} !== 71'b0)
      $display("FAIL midreset_outputs: got we=%b wi=%b rd=%b vd=%0d imm=%h addr=%h, expected 0",
               bus.write_enable, bus.write_imm, bus.mem_rd, bus.vd, bus.imm, bus.mem_addr);
    else n_pass++;
    tick(20);
    n_checks++;
    if (done_cnt != done0 || err_cnt != err0)
      $display("FAIL midreset_pulses: got done=%0d err=%0d, expected 0 0", done_cnt - done0, err_cnt - err0);
    else n_pass++;
    check_drained("midreset");
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_vd = '0;
    bus.alu_w1 = '0; bus.alu_w2 = '0; bus.alu_w3 = '0; bus.alu_w4 = '0;
    bus.ld_req = 1'b0;
    bus.ld_vd = '0;
    bus.ld_base = '0;
    fork
      monitor();
      mem_model();
    join_none
    test_reset();
    test_alu_only();
    test_back_to_back();
    test_load();
    test_collision();
    test_timeout();
    test_wrap_busy();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
